// File: rtl/nanoz80_pkg.sv
// Shared nanoz80 definitions: timer register map and CTRL/STATUS bit positions.
// Also used by addr_decoder when it forms timer_cs.
package nanoz80_pkg;

  localparam logic [2:0] TMR_CTRL     = 3'd0;
  localparam logic [2:0] TMR_STATUS   = 3'd1;
  localparam logic [2:0] TMR_PRESC    = 3'd2;
  localparam logic [2:0] TMR_RELOAD_L = 3'd3;
  localparam logic [2:0] TMR_RELOAD_H = 3'd4;
  localparam logic [2:0] TMR_COUNT_L  = 3'd5;
  localparam logic [2:0] TMR_COUNT_H  = 3'd6;
  localparam logic [2:0] TMR_RSVD     = 3'd7;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_IE  = 1;
  localparam int CTRL_OS  = 2;
  localparam int CTRL_LD  = 3;
  localparam int STAT_TF  = 0;
  localparam int STAT_RUN = 1;

  // Stored CTRL bits; packed so {5'b0, ctrl} is the CTRL read value.
  typedef struct packed {
    logic os;
    logic ie;
    logic en;
  } tmr_ctrl_t;

endpackage

// File: rtl/timer_prescaler.sv
// Clock divider: one-cycle tick every div+1 clocks while en; restart zeroes the phase.
// Tick is combinational from the phase counter; no backpressure.
module timer_prescaler (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en,
  input  logic       restart,
  input  logic [7:0] div,
  output logic       tick
);

  logic [7:0] cnt;

  // >= keeps the divider sane if div is lowered below the current phase
  assign tick = en & (cnt >= div);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= 8'd0;
    end else if (restart) begin
      cnt <= 8'd0;
    end else if (en) begin
      cnt <= tick ? 8'd0 : cnt + 8'd1;
    end
  end

endmodule

// File: rtl/irq_timer.sv
// 16-bit down-counting timer with prescaler and active-low IRQ; data_o registered (1 clk).
// Writes/COUNT_L reads act once per chip-select strobe; no backpressure.
module irq_timer
  import nanoz80_pkg::*;
#(
  parameter logic [15:0] RELOAD_RST = 16'hFFFF,
  parameter logic [7:0]  PRESC_RST  = 8'd0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       timer_cs,
  input  logic       wr_n,
  input  logic [2:0] reg_addr_i,
  input  logic [7:0] data_i,
  input  logic       int_ack_i,
  output logic [7:0] data_o,
  output logic       int_n_o
);

  tmr_ctrl_t   ctrl;
  logic        tf;
  logic [7:0]  presc;
  logic [15:0] reload;
  logic [15:0] count;
  logic [7:0]  shadow;
  logic        wr_prev, rd_prev, ack_prev;
  logic        wr_stb, rd_stb, ack_rise;
  logic        wr_ctrl, load_now, expire, tf_clr, tick;
  logic [7:0]  rd_mux;

  assign wr_stb   = timer_cs & ~wr_n & ~wr_prev;
  assign rd_stb   = timer_cs & wr_n & ~rd_prev;
  assign ack_rise = int_ack_i & ~ack_prev;

  assign wr_ctrl  = wr_stb & (reg_addr_i == TMR_CTRL);
  assign load_now = wr_ctrl & (data_i[CTRL_LD] | (data_i[CTRL_EN] & ~ctrl.en));
  assign expire   = tick & (count == 16'd0);
  assign tf_clr   = (wr_stb & (reg_addr_i == TMR_STATUS) & data_i[STAT_TF]) | ack_rise;
  assign int_n_o  = ~(tf & ctrl.ie);

  // An LD with EN written 0 loads COUNT but leaves the prescaler phase frozen
  timer_prescaler u_presc (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en      (ctrl.en),
    .restart (load_now & data_i[CTRL_EN]),
    .div     (presc),
    .tick    (tick)
  );

  always_comb begin
    rd_mux = 8'h00;
    case (reg_addr_i)
      TMR_CTRL:     rd_mux = {5'b0, ctrl};
      TMR_STATUS:   rd_mux = {6'b0, ctrl.en, tf};
      TMR_PRESC:    rd_mux = presc;
      TMR_RELOAD_L: rd_mux = reload[7:0];
      TMR_RELOAD_H: rd_mux = reload[15:8];
      TMR_COUNT_L:  rd_mux = count[7:0];
      TMR_COUNT_H:  rd_mux = shadow;
      default:      rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl     <= '0;
      tf       <= 1'b0;
      presc    <= PRESC_RST;
      reload   <= RELOAD_RST;
      count    <= 16'd0;
      shadow   <= 8'd0;
      wr_prev  <= 1'b0;
      rd_prev  <= 1'b0;
      ack_prev <= 1'b0;
      data_o   <= 8'h00;
    end else begin
      wr_prev  <= timer_cs & ~wr_n;
      rd_prev  <= timer_cs & wr_n;
      ack_prev <= int_ack_i;
      data_o   <= rd_mux;

      if (rd_stb && reg_addr_i == TMR_COUNT_L) shadow <= count[15:8];

      if (wr_stb) begin
        case (reg_addr_i)
          TMR_PRESC:    presc         <= data_i;
          TMR_RELOAD_L: reload[7:0]   <= data_i;
          TMR_RELOAD_H: reload[15:8]  <= data_i;
          default:      ;
        endcase
      end

      if (wr_ctrl) begin
        ctrl <= '{os: data_i[CTRL_OS], ie: data_i[CTRL_IE], en: data_i[CTRL_EN]};
      end else if (expire && ctrl.os) begin
        ctrl.en <= 1'b0;
      end

      if (load_now) begin
        count <= reload;
      end else if (tick) begin
        if (count != 16'd0) count <= count - 16'd1;
        else if (!ctrl.os)  count <= reload;
      end

      // Expiry beats a same-cycle clear
      if (expire)      tf <= 1'b1;
      else if (tf_clr) tf <= 1'b0;
    end
  end

endmodule
